// File: rtl/cache_pkg.sv
// Shared types and datapath mux select encodings for the cache sequencer.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    FILL_DONE = 2'd3
  } seq_state_e;

  localparam logic CACHE_SRC_MEM  = 1'b0;
  localparam logic CACHE_SRC_REG  = 1'b1;
  localparam logic MEM_ADDR_ALU   = 1'b0;
  localparam logic MEM_ADDR_CACHE = 1'b1;

endpackage

// File: rtl/mem_beat_counter.sv
// Memory latency counter plus word-in-line index, shared by writeback and refill.
module mem_beat_counter #(
  parameter int LINE_WORDS  = 4,
  parameter int MEM_LATENCY = 4,
  parameter int IDX_W       = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1,
  parameter int CNT_W       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic             beat_done,
  output logic             last_beat,
  output logic [IDX_W-1:0] word_idx
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LINE_WORDS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;

  assign beat_done = enable && (cnt_q == CNT_LAST);
  assign last_beat = (idx_q == IDX_LAST);
  assign word_idx  = idx_q;

  // Index returns to 0 after the final word so the next phase starts clean.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        idx_q <= last_beat ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cache_sequencer.sv
// Write-back direct-mapped cache miss sequencer: stalls the pipeline, writes back
// a dirty victim, refills the line word by word, then lets the access retry as a hit.
module cache_sequencer
  import cache_pkg::*;
#(
  parameter int LINE_WORDS  = 4,
  parameter int MEM_LATENCY = 4,
  parameter int IDX_W       = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             is_nop,
  input  logic             cache_hit,
  input  logic             cache_dirty,
  output logic             pc_enable,
  output logic             we_cache,
  output logic             set_valid,
  output logic             set_dirty,
  output logic             we_memory,
  output logic             cache_input_type,
  output logic             memory_address_type,
  output logic [IDX_W-1:0] word_idx,
  output logic             busy
);

  seq_state_e       state_q, state_d;
  logic             access;
  logic             beat_done, last_beat;
  logic             cnt_clear, cnt_enable;
  logic [IDX_W-1:0] cnt_idx;

  assign access     = (mem_read || mem_write) && !is_nop;
  assign cnt_enable = (state_q == WRITEBACK) || (state_q == REFILL);
  assign cnt_clear  = (state_q == IDLE) ||
                      ((state_q == WRITEBACK) && beat_done && last_beat);

  mem_beat_counter #(
    .LINE_WORDS (LINE_WORDS),
    .MEM_LATENCY(MEM_LATENCY),
    .IDX_W      (IDX_W)
  ) u_beat (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .beat_done(beat_done),
    .last_beat(last_beat),
    .word_idx (cnt_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (access && !cache_hit) state_d = cache_dirty ? WRITEBACK : REFILL;
      WRITEBACK: if (beat_done && last_beat) state_d = REFILL;
      REFILL:    if (beat_done && last_beat) state_d = FILL_DONE;
      FILL_DONE: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Everything is held at 0 during reset, including pc_enable.
  always_comb begin
    pc_enable           = 1'b0;
    we_cache            = 1'b0;
    set_valid           = 1'b0;
    set_dirty           = 1'b0;
    we_memory           = 1'b0;
    cache_input_type    = CACHE_SRC_MEM;
    memory_address_type = MEM_ADDR_ALU;
    word_idx            = '0;
    busy                = 1'b0;
    if (!rst) begin
      word_idx = cnt_idx;
      busy     = (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          pc_enable = !access || cache_hit;
          if (access && cache_hit && mem_write) begin
            we_cache         = 1'b1;
            cache_input_type = CACHE_SRC_REG;
            set_dirty        = 1'b1;
          end
        end
        WRITEBACK: begin
          memory_address_type = MEM_ADDR_CACHE;
          we_memory           = beat_done;
        end
        REFILL: begin
          memory_address_type = MEM_ADDR_ALU;
          cache_input_type    = CACHE_SRC_MEM;
          we_cache            = beat_done;
        end
        FILL_DONE: set_valid = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_sequencer.sv
// Randomized bench for cache_sequencer against a miss-timeline reference model.
module tb_cache_sequencer;
  import cache_pkg::*;

  localparam int LW    = 4;
  localparam int ML    = 4;
  localparam int IDX_W = (LW > 1) ? $clog2(LW) : 1;
  localparam int LM    = LW * ML;
  localparam int OW    = 8 + IDX_W;

  logic clk = 1'b0;
  logic rst, mem_read, mem_write, is_nop, cache_hit, cache_dirty;
  logic pc_enable, we_cache, set_valid, set_dirty, we_memory;
  logic cache_input_type, memory_address_type, busy;
  logic [IDX_W-1:0] word_idx;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: idle, or busy at offset t (1-based) into a miss timeline.
  bit m_busy  = 1'b0;
  bit m_dirty = 1'b0;
  int m_t     = 0;

  always #5 clk = ~clk;

  cache_sequencer #(.LINE_WORDS(LW), .MEM_LATENCY(ML), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .is_nop(is_nop), .cache_hit(cache_hit), .cache_dirty(cache_dirty),
    .pc_enable(pc_enable), .we_cache(we_cache), .set_valid(set_valid),
    .set_dirty(set_dirty), .we_memory(we_memory),
    .cache_input_type(cache_input_type), .memory_address_type(memory_address_type),
    .word_idx(word_idx), .busy(busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit w, input bit n, input bit h,
                      input bit d, input bit rs);
    bit e_pc, e_wc, e_sv, e_sd, e_wm, e_cit, e_mat, e_busy, acc;
    int e_idx, u;
    logic [OW-1:0] got_v, exp_v;
    @(negedge clk);
    mem_read = r; mem_write = w; is_nop = n; cache_hit = h; cache_dirty = d; rst = rs;
    #1;
    {e_pc, e_wc, e_sv, e_sd, e_wm, e_cit, e_mat, e_busy} = '0;
    e_idx = 0;
    acc = (r || w) && !n;
    if (rs) begin
      e_idx = 0;
    end else if (!m_busy) begin
      e_pc = !acc || h;
      if (acc && h && w) begin e_wc = 1; e_cit = 1; e_sd = 1; end
    end else begin
      e_busy = 1;
      u = m_t - 1;
      if (m_dirty && u < LM) begin
        e_mat = 1; e_wm = (u % ML == ML - 1); e_idx = u / ML;
      end else begin
        if (m_dirty) u -= LM;
        if (u < LM) begin e_wc = (u % ML == ML - 1); e_idx = u / ML; end
        else e_sv = 1;
      end
    end
    exp_v = {e_pc, e_wc, e_sv, e_sd, e_wm, e_cit, e_mat, IDX_W'(e_idx), e_busy};
    got_v = {pc_enable, we_cache, set_valid, set_dirty, we_memory,
             cache_input_type, memory_address_type, word_idx, busy};
    check("outputs", int'(got_v), int'(exp_v));
    if (rs) m_busy = 0;
    else if (!m_busy) begin
      if (acc && !h) begin m_busy = 1; m_t = 1; m_dirty = d; end
    end else begin
      m_t++;
      if (m_t > (m_dirty ? 2 : 1) * LM + 1) m_busy = 0;
    end
  endtask

  initial begin
    int sv_cyc, pc_cyc, wm_cnt, wc_cnt, st_cyc;
    rst = 1; mem_read = 0; mem_write = 0; is_nop = 0; cache_hit = 0; cache_dirty = 0;
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    check("rst_pc", int'(pc_enable), 0);

    // Read hit and write hit
    step(1, 0, 0, 1, 0, 0);
    check("rd_hit_pc", int'(pc_enable), 1);
    check("rd_hit_busy", int'(busy), 0);
    step(0, 1, 0, 1, 1, 0);
    check("wr_hit_we", int'({we_cache, cache_input_type, set_dirty, pc_enable}), 15);

    // Clean read miss
    sv_cyc = -1; pc_cyc = -1;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 18; i++) begin
      step(1, 0, 0, 1, 0, 0);
      if (set_valid) sv_cyc = i;
      if (pc_enable && pc_cyc < 0) pc_cyc = i;
    end
    check("clean_sv_cycle", sv_cyc, 17);
    check("clean_pc_cycle", pc_cyc, 18);

    // Dirty write miss
    wm_cnt = 0; wc_cnt = 0; sv_cyc = -1; st_cyc = -1;
    step(0, 1, 0, 0, 1, 0);
    for (int i = 1; i <= 34; i++) begin
      step(0, 1, 0, 1, 1, 0);
      if (we_memory) wm_cnt++;
      if (we_cache && !set_dirty) wc_cnt++;
      if (set_valid) sv_cyc = i;
      if (we_cache && set_dirty && pc_enable) st_cyc = i;
    end
    check("dirty_wm_count", wm_cnt, LW);
    check("dirty_refill_count", wc_cnt, LW);
    check("dirty_sv_cycle", sv_cyc, 33);
    check("dirty_store_cycle", st_cyc, 34);

    // Reset in the middle of a clean refill
    step(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_idx", int'(word_idx), 0);
    sv_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (set_valid) sv_cyc++;
    end
    check("mid_rst_no_sv", sv_cyc, 0);

    // NOP suppresses a missing store
    step(0, 1, 1, 0, 1, 0);
    check("nop_pc", int'(pc_enable), 1);
    step(0, 1, 1, 0, 1, 0);
    check("nop_busy", int'(busy), 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
           1'($urandom), 1'($urandom), ($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
